// File: rtl/res_writeback_pkg.sv
// res_writeback_pkg: shared constants and state encoding for the result writeback stage
package res_writeback_pkg;
  localparam int WORD_WIDTH = 256;
  localparam int SINGLE_ACCESS = 4;
  localparam int RES_ADDR = 0;
  localparam int OP_ADDR = 0;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR_OP, DONE} wb_state_t;
endpackage

// File: rtl/res_writeback_block_fifo.sv
// block_fifo: small FIFO of whole result blocks with a combinational head
module block_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/res_writeback.sv
// res_writeback: buffers finished result blocks and streams them word by word into memory C
module res_writeback #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = res_writeback_pkg::WORD_WIDTH,
  parameter int SINGLE_ACCESS = res_writeback_pkg::SINGLE_ACCESS,
  parameter int FIFO_DEPTH = 2,
  parameter int RES_BASE = res_writeback_pkg::RES_ADDR,
  parameter int OP_ADDR = res_writeback_pkg::OP_ADDR,
  parameter int INSTR_ADDR_WIDTH = 10,
  parameter int BLK_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [BLK_WIDTH-1:0]              total_blocks,
  input  logic                              res_valid,
  input  logic [SINGLE_ACCESS*WORD_WIDTH-1:0] res_data,
  output logic                              res_ready,
  output logic [ADDR_WIDTH-1:0]             mem_c_address,
  output logic                              mem_c_chipselect,
  output logic                              mem_c_write,
  output logic [WORD_WIDTH-1:0]             mem_c_writedata,
  output logic [WORD_WIDTH/8-1:0]           mem_c_byteenable,
  output logic [INSTR_ADDR_WIDTH-1:0]       instr_address,
  output logic                              instr_chipselect,
  output logic                              instr_write,
  output logic [31:0]                       instr_writedata,
  output logic                              busy,
  output logic                              done
);
  import res_writeback_pkg::*;
  localparam int IW = SINGLE_ACCESS > 1 ? $clog2(SINGLE_ACCESS) : 1;
  localparam int BW = SINGLE_ACCESS * WORD_WIDTH;
  wb_state_t state;
  logic [BLK_WIDTH-1:0] total, accepted_cnt, written_cnt;
  logic [IW-1:0] word_idx;
  logic [BW-1:0] head;
  logic full, empty, push, pop, wr, last_word;
  block_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BW)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(res_data),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // no full-FIFO bypass: acceptance never relies on a same-cycle pop
  assign res_ready = state == WRITE && !full && accepted_cnt < total;
  assign push = res_valid && res_ready;
  assign wr = state == WRITE && !empty;
  assign last_word = word_idx == IW'(SINGLE_ACCESS - 1);
  assign pop = wr && last_word;
  assign mem_c_write = wr;
  assign mem_c_chipselect = wr;
  assign mem_c_address = wr ? ADDR_WIDTH'(RES_BASE + int'(written_cnt) * SINGLE_ACCESS + int'(word_idx)) : '0;
  assign mem_c_writedata = wr ? head[int'(word_idx)*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign mem_c_byteenable = '1;
  assign instr_address = INSTR_ADDR_WIDTH'(OP_ADDR);
  assign instr_write = state == CLEAR_OP;
  assign instr_chipselect = instr_write;
  assign instr_writedata = '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      total <= '0;
      accepted_cnt <= '0;
      written_cnt <= '0;
      word_idx <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            total <= total_blocks;
            accepted_cnt <= '0;
            written_cnt <= '0;
            word_idx <= '0;
            state <= total_blocks == '0 ? CLEAR_OP : WRITE;
          end
        WRITE: begin
          if (push) accepted_cnt <= accepted_cnt + 1'b1;
          if (wr) word_idx <= last_word ? '0 : word_idx + 1'b1;
          if (pop) begin
            written_cnt <= written_cnt + 1'b1;
            if (written_cnt + 1'b1 == total) state <= CLEAR_OP;
          end
        end
        CLEAR_OP: state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_res_writeback.sv
// tb_res_writeback: table-driven and randomized checks of res_writeback against a word-queue model
module tb_res_writeback;
  localparam int AW = 11;
  localparam int WW = 256;
  localparam int SA = 4;
  localparam int BASE = 16;
  localparam int OPA = 5;

  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  typedef struct {
    int total;
    int pct;
    bit fixed;
    bit poke;
    int exp_done;
    bit exp_bp;
  } vec_t;

  logic clock = 1'b0;
  logic reset, start, res_valid, res_ready;
  logic [15:0] total_blocks;
  logic [SA*WW-1:0] res_data;
  logic [AW-1:0] mem_c_address;
  logic mem_c_chipselect, mem_c_write;
  logic [WW-1:0] mem_c_writedata;
  logic [WW/8-1:0] mem_c_byteenable;
  logic [9:0] instr_address;
  logic instr_chipselect, instr_write;
  logic [31:0] instr_writedata;
  logic busy, done;
  int passed = 0;
  int checks = 0;

  always #5 clock = ~clock;

  res_writeback #(.RES_BASE(BASE), .OP_ADDR(OPA)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .total_blocks(total_blocks),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready),
    .mem_c_address(mem_c_address),
    .mem_c_chipselect(mem_c_chipselect),
    .mem_c_write(mem_c_write),
    .mem_c_writedata(mem_c_writedata),
    .mem_c_byteenable(mem_c_byteenable),
    .instr_address(instr_address),
    .instr_chipselect(instr_chipselect),
    .instr_write(instr_write),
    .instr_writedata(instr_writedata),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] w;
    for (int j = 0; j < WW / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  // Model: an operation of N blocks is the word stream BASE+k, k = 0..4N-1, in offer order
  task automatic run_op(input vec_t v);
    logic [SA*WW-1:0] blks[$];
    wr_t q[$];
    wr_t e;
    logic [SA*WW-1:0] b;
    logic [WW-1:0] w;
    int cyc, acc, nwr, first, last, done_cyc, instr_cyc, low, over, bad_instr, bad_cs;
    acc = 0; nwr = 0; first = -1; last = -1; done_cyc = -1; instr_cyc = -1;
    low = 0; over = 0; bad_instr = 0; bad_cs = 0;
    for (int k = 0; k < v.total; k++) begin
      b = '0;
      for (int i = 0; i < SA; i++) begin
        w = v.fixed ? WW'(32'hA0 + 16 * k + i) : rnd_word();
        b[i*WW +: WW] = w;
        q.push_back('{AW'(BASE + SA * k + i), w});
      end
      blks.push_back(b);
    end
    @(negedge clock);
    start = 1'b1;
    total_blocks = 16'(v.total);
    res_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (mem_c_write) begin
        nwr++;
        if (first < 0) first = cyc;
        last = cyc;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wr_addr", mem_c_address, e.a);
          chk("wr_data", mem_c_writedata, e.d);
        end
      end
      if (mem_c_chipselect !== mem_c_write || instr_chipselect !== instr_write) bad_cs++;
      if (instr_write) begin
        instr_cyc = cyc;
        if (instr_address !== 10'(OPA) || instr_writedata !== 32'd0) bad_instr++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (acc < v.total && !res_ready) low++;
      if (acc >= v.total && res_ready) over++;
      start = v.poke && cyc == 3;
      total_blocks = v.poke ? 16'd9 : 16'(v.total);
      res_valid = v.pct == 100 || (acc < v.total && $urandom_range(99) < v.pct);
      res_data = v.total == 0 ? '0 : blks[acc < v.total ? acc : v.total - 1];
      if (res_valid && res_ready) acc++;
      @(negedge clock);
      cyc++;
    end
    res_valid = 1'b0;
    start = 1'b0;
    if (v.exp_done >= 0) chk("done_cyc", done_cyc, v.exp_done);
    else chk("done_seen", done_cyc >= 0, 1'b1);
    chk("n_writes", nwr, SA * v.total);
    chk("accepted", acc, v.total);
    chk("over_accept", over, 0);
    chk("instr_cyc", instr_cyc, done_cyc - 1);
    chk("instr_fields", bad_instr, 0);
    chk("chipselects", bad_cs, 0);
    if (v.total > 0) chk("done_after_last_wr", done_cyc - last, 2);
    if (v.pct == 100 && v.total > 0) begin
      chk("first_wr_cyc", first, 2);
      chk("no_bubble", last - first, nwr - 1);
    end
    if (v.exp_bp) chk("ready_dropped", low > 0, 1'b1);
    @(negedge clock);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t rv;
    logic [SA*WW-1:0] b;
    bit found;
    int bad;
    vecs[0] = '{1, 100, 1'b1, 1'b0, 7, 1'b0};
    vecs[1] = '{3, 100, 1'b0, 1'b0, 15, 1'b1};
    vecs[2] = '{0, 100, 1'b0, 1'b0, 2, 1'b0};
    vecs[3] = '{4, 100, 1'b0, 1'b0, 19, 1'b1};
    vecs[4] = '{1, 100, 1'b0, 1'b1, 7, 1'b0};
    vecs[5] = '{5, 50, 1'b0, 1'b0, -1, 1'b0};
    reset = 1'b1;
    start = 1'b0;
    total_blocks = '0;
    res_valid = 1'b0;
    res_data = '0;
    repeat (2) @(negedge clock);
    chk("rst_mem_write", mem_c_write, 1'b0);
    chk("rst_mem_cs", mem_c_chipselect, 1'b0);
    chk("rst_mem_addr", mem_c_address, '0);
    chk("rst_mem_data", mem_c_writedata, '0);
    chk("rst_byteen", mem_c_byteenable, {(WW/8){1'b1}});
    chk("rst_instr_addr", instr_address, 10'(OPA));
    chk("rst_instr_write", instr_write, 1'b0);
    chk("rst_instr_cs", instr_chipselect, 1'b0);
    chk("rst_instr_data", instr_writedata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", res_ready, 1'b0);
    reset = 1'b0;

    // abandon an operation with an asynchronous reset during word 2 of block 0
    for (int i = 0; i < SA; i++) b[i*WW +: WW] = rnd_word();
    @(negedge clock);
    start = 1'b1;
    total_blocks = 16'd2;
    @(negedge clock);
    start = 1'b0;
    res_valid = 1'b1;
    res_data = b;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_c_write && mem_c_address == AW'(BASE + 2)) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_found", found, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_write", mem_c_write, 1'b0);
    chk("async_instr_write", instr_write, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", res_ready, 1'b0);
    chk("async_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    res_valid = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (done || mem_c_write || instr_write) bad++;
    end
    chk("quiet_after_reset", bad, 0);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    for (int i = 0; i < 20; i++) begin
      rv.total = $urandom_range(5);
      rv.pct = $urandom_range(3) == 0 ? 100 : $urandom_range(95, 20);
      rv.fixed = 1'b0;
      rv.poke = 1'b0;
      rv.exp_done = rv.pct == 100 ? (rv.total == 0 ? 2 : SA * rv.total + 3) : -1;
      rv.exp_bp = rv.pct == 100 && rv.total >= 3;
      run_op(rv);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/res_writeback.md
Name: res_writeback

Overview:
- Downstream stage of the matrix compute FSM/datapath. Accepts finished result blocks, each `SINGLE_ACCESS` words of 256 bits, through a valid/ready handshake.
- Buffers blocks in a small FIFO and streams them one word per cycle into result memory C.
- When the operation's last block is written, it clears the op word in instruction memory and pulses done.
- Decouples compute from the single-port result write, so compute can start the next block while writes drain.

Parameters:
- ADDR_WIDTH, 11, result memory word address width
- WORD_WIDTH, 256, memory word width (`DATA_WIDTH*`BANDWIDTH)
- SINGLE_ACCESS, 4, words per result block
- FIFO_DEPTH, 2, block-FIFO capacity in blocks (power of 2, >=2)
- RES_BASE, 0, base word address of the result region in memory C
- OP_ADDR, 0, instruction memory address of the op word
- INSTR_ADDR_WIDTH, 10, instruction memory address width
- BLK_WIDTH, 16, width of block counters

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins an operation; accepted only in IDLE
- total_blocks  in  BLK_WIDTH  blocks to write for this operation; sampled on accepted start
- res_valid  in  1  a result block is offered
- res_data  in  SINGLE_ACCESS*WORD_WIDTH  block payload; word i at bits [WORD_WIDTH*(i+1)-1 : WORD_WIDTH*i]
- res_ready  out  1  block accepted on a clock edge where res_valid && res_ready
- mem_c_address  out  ADDR_WIDTH  result write address
- mem_c_chipselect  out  1  equals mem_c_write
- mem_c_write  out  1  result write strobe
- mem_c_writedata  out  WORD_WIDTH  result write data
- mem_c_byteenable  out  WORD_WIDTH/8  constant all ones
- instr_address  out  INSTR_ADDR_WIDTH  op-word address
- instr_chipselect  out  1  equals instr_write
- instr_write  out  1  op-word clear strobe
- instr_writedata  out  32  constant 0
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse when the operation completes

Behaviour:
- Reset: state IDLE, FIFO empty, all counters 0. Every output is 0, except mem_c_byteenable (all ones) and instr_address (OP_ADDR). Reset mid-operation abandons the operation: queued blocks are discarded and no done or op clear is issued.
- Output timing: memory and instruction outputs are combinational from registered state, counters and the FIFO head. There are no write-response waits.
- IDLE:
  - On start, latch total_blocks, clear accepted_cnt, written_cnt and word_idx.
  - If total_blocks == 0, go to CLEAR_OP. Otherwise go to WRITE.
- WRITE, handshake:
  - res_ready = !fifo_full && (accepted_cnt < total_blocks).
  - Blocks beyond total_blocks are never accepted.
  - res_ready does not depend on a same-cycle pop (no full-FIFO bypass).
- WRITE, draining:
  - If the FIFO is non-empty, assert mem_c_write with address = RES_BASE + written_cnt*SINGLE_ACCESS + word_idx, truncated mod 2^ADDR_WIDTH (wraps).
  - Write data = head word[word_idx]. word_idx increments each write.
  - At word_idx == SINGLE_ACCESS-1: pop the head, reset word_idx to 0, increment written_cnt.
  - No bubble between blocks when the next block is already queued.
  - If the FIFO is empty, no write that cycle and word_idx holds.
- WRITE, push/pop: a simultaneous push and pop in the same cycle is legal and leaves the occupancy unchanged.
- Latency: a block accepted at edge t into an empty FIFO has its word 0 written during cycle t+1. Its last word is written in cycle t+SINGLE_ACCESS.
- WRITE exit: when written_cnt reaches total_blocks (after the final pop), go to CLEAR_OP.
- CLEAR_OP: a single cycle asserting instr_write (instr_writedata 0 at OP_ADDR), then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Start outside IDLE: ignored, with no effect on counters.
- Width rule: counters are BLK_WIDTH bits. total_blocks*SINGLE_ACCESS must fit in ADDR_WIDTH; larger values wrap and are out of contract.

Decomposition:
- Shared package (Macro.svh / pkg) holds:
  - constants WORD_WIDTH, SINGLE_ACCESS, RES_ADDR and OP_ADDR;
  - a wb_state_t enum {IDLE, WRITE, CLEAR_OP, DONE}.
- One sub-module, block_fifo:
  - parameters DEPTH and WIDTH = SINGLE_ACCESS*WORD_WIDTH;
  - ports push, pop, din, dout (head, combinational), full, empty;
  - pointers one bit wider than log2(DEPTH), for full/empty disambiguation.

Test Plan:
- Single block: start with total=1; at edge t offer words 0xA0..0xA3.
  - Required: writes at RES_BASE+0..3 in cycles t+1..t+4 carrying 0xA0..0xA3.
  - Then instr_write of 0 at OP_ADDR, then a done pulse, then busy low.
- Back-to-back: total=3, res_valid held high with blocks B0, B1, B2.
  - Required: 12 consecutive writes, addresses 0..11, no idle cycle between blocks.
  - Required: done exactly 2 cycles after the final write.
- Zero length: total=0.
  - Required: no mem_c_write; instr_write in the cycle after start; done one cycle later.
- Backpressure: total=4, res_valid held high from the start.
  - Required: res_ready drops while the FIFO holds 2 blocks.
  - Required: exactly 4 blocks accepted; res_ready stays 0 after the 4th even with res_valid high.
  - Required: the address sequence is 0..15.
- Reset mid-write: assert reset while word_idx=2 of block 0, total=2.
  - Required: all strobes 0 immediately (asynchronous reset); no done.
  - Required: a fresh start with total=1 writes from address RES_BASE.
- Start ignored: pulse start with total=9 during WRITE of a total=1 operation.
  - Required: the operation completes after 4 writes, and total is not reloaded.
